// File: rtl/stdin_pkg.sv
// Shared address map and register layout for the simulation stdin device.
package stdin_pkg;

    // Memory-mapped simulation I/O windows; each device owns a 16-byte aligned slot.
    localparam logic [63:0] STDOUT_BASE_ADDR = 64'h0000_0000_1000_0000;
    localparam logic [63:0] STDIN_BASE_ADDR  = 64'h0000_0000_1000_0010;
    localparam logic [63:0] STDIN_WINDOW     = 64'd16;

    // Register offsets inside the stdin window.
    localparam int STDIN_DATA_OFF   = 0;
    localparam int STDIN_STATUS_OFF = 8;

    // STATUS register bit positions.
    localparam int STATUS_NONEMPTY  = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_EOF       = 2;
    localparam int STATUS_COUNT_LSB = 8;

    // Value returned by a DATA read of an empty FIFO (C-style EOF, -1).
    localparam logic [63:0] STDIN_EOF_WORD = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        SLOT_NONE,
        SLOT_DATA,
        SLOT_STATUS
    } stdin_slot_e;

    // Classify an address: outside the window, DATA slot or STATUS slot.
    // Only bit 3 selects the register; the low three bits are don't-care.
    function automatic stdin_slot_e decode_slot(input logic [63:0] addr);
        stdin_slot_e slot;
        slot = SLOT_NONE;
        if ((addr >= STDIN_BASE_ADDR) && (addr < (STDIN_BASE_ADDR + STDIN_WINDOW))) begin
            slot = addr[3] ? SLOT_STATUS : SLOT_DATA;
        end
        return slot;
    endfunction

endpackage

// File: rtl/stdin_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; head entry is visible combinationally.
module stdin_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The MSB of each pointer distinguishes full from empty when the indices match,
    // so the occupancy is simply the pointer difference.
    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr[AW-1:0]];

    // Requests are guarded here as well so the FIFO can never overwrite or underflow.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer update; both wrap naturally modulo 2*DEPTH, indexing modulo DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/stdin.sv
// Simulation stdin device: host pushes bytes into a FIFO, CPU drains them with loads.
module stdin
    import stdin_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] addr,
    input  logic        mem_read,
    output logic [63:0] r_data,
    input  logic        host_valid,
    input  logic [7:0]  host_data,
    input  logic        host_eof,
    output logic        host_ready,
    output logic        stdin_waiting
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    stdin_slot_e      slot;
    logic [7:0]       head_data;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             eof_flag;
    logic             empty_read;

    // Assemble the STATUS word; the count field is eight bits wide, zero-extended.
    function automatic logic [63:0] status_word(input logic [CNT_W-1:0] cnt,
                                                input logic             eof,
                                                input logic             is_full,
                                                input logic             nonempty);
        logic [63:0] w;
        w                   = '0;
        w[STATUS_NONEMPTY]  = nonempty;
        w[STATUS_FULL]      = is_full;
        w[STATUS_EOF]       = eof;
        w                   = w | ((64'(cnt) << STATUS_COUNT_LSB) & 64'h0000_0000_0000_FF00);
        return w;
    endfunction

    assign slot = decode_slot(addr);

    // host_ready follows the registered occupancy only; a same-cycle pop does not raise it.
    assign host_ready = !full;
    assign push       = host_valid && host_ready;
    assign pop        = mem_read && (slot == SLOT_DATA) && !empty;
    assign empty_read = mem_read && (slot == SLOT_DATA) && empty && !eof_flag;

    stdin_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (host_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Load-data mux: driven purely by address and current state, independent of mem_read.
    always_comb begin
        r_data = '0;
        unique case (slot)
            SLOT_DATA:   r_data = empty ? STDIN_EOF_WORD : {56'h0, head_data};
            SLOT_STATUS: r_data = status_word(count, eof_flag, full, !empty);
            default:     r_data = '0;
        endcase
    end

    // Sticky end-of-input flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            eof_flag <= 1'b0;
        end else if (host_eof) begin
            eof_flag <= 1'b1;
        end
    end

    // CPU-starved indicator: set by an empty read before EOF, cleared by new data or EOF.
    // Clearing takes priority when both happen in one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            stdin_waiting <= 1'b0;
        end else if (push || host_eof) begin
            stdin_waiting <= 1'b0;
        end else if (empty_read) begin
            stdin_waiting <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stdin.sv
// Directed self-checking bench for the simulation stdin device.
module tb_stdin;
    import stdin_pkg::*;

    localparam logic [63:0] DATA_ADDR   = STDIN_BASE_ADDR + 64'(STDIN_DATA_OFF);
    localparam logic [63:0] STATUS_ADDR = STDIN_BASE_ADDR + 64'(STDIN_STATUS_OFF);

    logic        clock;
    logic        reset;
    logic [63:0] addr;
    logic        mem_read;
    logic [63:0] r_data;
    logic        host_valid;
    logic [7:0]  host_data;
    logic        host_eof;
    logic        host_ready;
    logic        stdin_waiting;

    int checks;
    int errors;
    logic [7:0] q[$];
    logic [7:0] b;

    stdin #(.DEPTH(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .addr          (addr),
        .mem_read      (mem_read),
        .r_data        (r_data),
        .host_valid    (host_valid),
        .host_data     (host_data),
        .host_eof      (host_eof),
        .host_ready    (host_ready),
        .stdin_waiting (stdin_waiting)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] v);
        host_valid = 1'b1;
        host_data  = v;
        step();
        host_valid = 1'b0;
    endtask

    task automatic read_data(input string tag, input logic [63:0] exp);
        addr     = DATA_ADDR;
        mem_read = 1'b1;
        #1;
        check(tag, r_data, exp);
        step();
        mem_read = 1'b0;
        addr     = '0;
    endtask

    task automatic read_status(input string tag, input logic [63:0] exp);
        addr     = STATUS_ADDR;
        mem_read = 1'b1;
        #1;
        check(tag, r_data, exp);
        step();
        mem_read = 1'b0;
        addr     = '0;
    endtask

    // Push and pop in the same cycle; the popped value is the head before the edge.
    task automatic push_pop(input string tag, input logic [7:0] v, input logic [63:0] exp);
        host_valid = 1'b1;
        host_data  = v;
        addr       = DATA_ADDR;
        mem_read   = 1'b1;
        #1;
        check(tag, r_data, exp);
        step();
        host_valid = 1'b0;
        mem_read   = 1'b0;
        addr       = '0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        addr       = '0;
        mem_read   = 1'b0;
        host_valid = 1'b0;
        host_data  = '0;
        host_eof   = 1'b0;
        step();
        step();
        reset = 1'b0;

        // 1: reset state and empty reads
        check("rst_ready", 64'(host_ready), 64'd1);
        check("rst_waiting", 64'(stdin_waiting), 64'd0);
        read_data("empty_data", STDIN_EOF_WORD);
        check("waiting_set", 64'(stdin_waiting), 64'd1);
        read_status("empty_status", 64'h0);
        check("idle_out_of_window", r_data, 64'h0);

        // 2: two bytes in, two bytes out
        push_byte(8'h48);
        check("waiting_clr_push", 64'(stdin_waiting), 64'd0);
        push_byte(8'h69);
        read_status("status_two", 64'h0201);
        read_data("data_H", 64'h48);
        read_data("data_i", 64'h69);
        read_status("status_drained", 64'h0);

        // 3: fill to full, reject overflow, one pop frees a slot
        host_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            host_data = 8'(i);
            step();
        end
        check("full_ready", 64'(host_ready), 64'd0);
        host_data = 8'hAA;
        step();
        host_valid = 1'b0;
        read_status("status_full", 64'h1003);
        read_data("full_head", 64'h00);
        check("ready_after_pop", 64'(host_ready), 64'd1);
        for (int i = 1; i < 16; i++) begin
            read_data("full_drain", 64'(i));
        end
        read_status("status_after_full", 64'h0);

        // 4: simultaneous push/pop and pointer wrap
        q.delete();
        for (int i = 0; i < 5; i++) begin
            b = 8'h10 + 8'(i);
            push_byte(b);
            q.push_back(b);
        end
        b = q.pop_front();
        push_pop("pp_first", 8'h55, 64'(b));
        q.push_back(8'h55);
        read_status("pp_count5", 64'h0501);
        for (int i = 0; i < 40; i++) begin
            b = q.pop_front();
            push_pop("pp_wrap", 8'h80 + 8'(i), 64'(b));
            q.push_back(8'h80 + 8'(i));
        end
        read_status("wrap_count5", 64'h0501);
        for (int i = 0; i < 5; i++) begin
            b = q.pop_front();
            read_data("wrap_drain", 64'(b));
        end
        push_byte(8'h77);
        push_pop("pp_last", 8'h78, 64'h77);
        read_status("pp_last_count1", 64'h0101);
        read_data("pp_last_head", 64'h78);

        // 5: EOF handling
        read_data("pre_eof_empty", STDIN_EOF_WORD);
        check("pre_eof_waiting", 64'(stdin_waiting), 64'd1);
        push_byte(8'h41);
        host_eof = 1'b1;
        step();
        host_eof = 1'b0;
        read_status("eof_status", 64'h0105);
        read_data("eof_byte", 64'h41);
        read_data("eof_empty", STDIN_EOF_WORD);
        read_status("eof_status_empty", 64'h0004);
        check("eof_no_waiting", 64'(stdin_waiting), 64'd0);

        // 6: out-of-window accesses and mid-stream reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        addr     = STDIN_BASE_ADDR + 64'd16;
        mem_read = 1'b1;
        #1;
        check("above_window", r_data, 64'h0);
        step();
        addr = STDOUT_BASE_ADDR;
        #1;
        check("stdout_window", r_data, 64'h0);
        step();
        mem_read = 1'b0;
        addr     = STATUS_ADDR + 64'd7;
        #1;
        check("status_low_bits_ignored", r_data, 64'h0301);
        host_eof = 1'b1;
        step();
        host_eof = 1'b0;
        read_status("pre_reset_status", 64'h0305);
        reset = 1'b1;
        step();
        reset = 1'b0;
        addr  = STATUS_ADDR;
        #1;
        check("post_reset_status", r_data, 64'h0);
        check("post_reset_ready", 64'(host_ready), 64'd1);
        check("post_reset_waiting", 64'(stdin_waiting), 64'd0);
        addr = DATA_ADDR;
        #1;
        check("post_reset_data", r_data, STDIN_EOF_WORD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
